mod_const_mac_pipe: RTL and testbench
=====================================

Name: mod_const_mac_pipe

Overview:
- Streaming, parametrised residue multiply/multiply-accumulate unit: out = (x * CONST) mod MOD, optionally folded into a running modular accumulator.
- Successor to the fixed 6-bit single-constant combinational residue mappings (mod 53, scale 400).
- MOD, CONST and mode are generic; valid/ready flow control and a 3-stage pipeline are added.
- Sits between residue-channel producers and the modular combine logic.

Parameters:
- MOD, 53, modulus; 2 <= MOD <= 65535.
- CONST, 400, multiplier constant; reduced at elaboration to K = CONST mod MOD.
- W, $clog2(MOD), residue width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts beat this cycle
- in_data  in  W  residue x; canonical range 0..MOD-1
- in_mode  in  2  00 = multiply; 01 = multiply-accumulate; 10 = clear-then-accumulate; 11 = reserved, treated as 00
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- out_data  out  W  result residue
- out_err  out  1  input beat was non-canonical (x >= MOD)
- acc_value  out  W  current accumulator contents

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valids, out_valid, out_data, out_err and acc_value go to 0.
  - in_ready is 0 while rst=1.
  - In-flight beats are discarded, not output.
- Handshake:
  - A beat transfers when valid and ready are both 1 on the same edge.
  - out_data, out_err and out_valid hold stable while out_valid=1 and out_ready=0.
- Pipeline: S1, S2, S3; S3 is the output register.
  - Stage n advances when it is empty or stage n+1 advances.
  - in_ready = ~v1 | adv1, so bubbles collapse.
  - Latency is 3 cycles from input transfer to out_valid when there is no backpressure; full throughput is 1 beat/cycle.
- S1: registers x and mode.
  - err = (x >= MOD).
  - P = x*K, 2W bits; P is forced to 0 when err=1.
- S2: Barrett estimate.
  - mu = floor(2^(2W)/MOD) is an elaboration constant.
  - q = (P*mu) >> 2W; r = P - q*MOD; r < 3*MOD guaranteed.
- S3: result and accumulate.
  - At most two conditional subtractions of MOD give res in 0..MOD-1.
  - Mode 00: out_data = res; accumulator unchanged.
  - Mode 01: acc_n = (acc + res) mod MOD via one conditional subtract; out_data = acc_n; acc updates on the S3 load edge.
  - Mode 10: acc_n = res; out_data = res.
- Error beats: out_data = 0, out_err = 1, and the accumulator is NOT modified in any mode.
- Ordering: accumulator updates occur strictly in input order.
  - A stalled S3 beat has already updated acc.
  - Later beats update only when they themselves load S3.
- Wrap-around: acc + res <= 2*MOD-2 always; one subtract suffices.
- MOD a power of two: Barrett path remains valid and needs no special case.
- rst asserted mid-stream takes precedence over any advance in the same cycle.

Decomposition:
- Package mod_calc_pkg:
  - function clog2_f;
  - function barrett_mu(MOD, W);
  - function const_reduce(CONST, MOD);
  - typedef enum mode_e {MODE_MUL, MODE_MAC, MODE_CLRMAC};
  - packed struct stage_t {valid, err, mode, data}.
- Sub-module mod_reduce_barrett (params MOD, W):
  - covers the S2/S3 reduction: 2W-bit P in, W-bit residue out;
  - one register boundary inside, matching the S2/S3 split.
- Top module holds S1, handshake control and the accumulator.

Test Plan:
- Defaults (MOD=53, K=29), mode 00, x=1, 2, 52 back-to-back, out_ready=1 -> out_data 29, 5, 24 on cycles 3, 4, 5 after the first transfer; out_err=0.
- Mode 01 x=1, then 01 x=1, then 10 x=2 -> out_data 29, 5, 5; acc_value ends at 5.
- x=53, mode 01, with acc=29 -> out_data 0, out_err=1, acc_value stays 29.
- out_ready=0 for 10 cycles during a 5-beat burst:
  - in_ready drops after 3 beats are held;
  - out_data stays stable;
  - no beat is lost or duplicated;
  - sequence resumes in order when out_ready=1.
- rst pulsed with 2 beats in flight -> no out_valid for those beats; acc_value=0; the next beat x=3 gives 87 mod 53 = 34.
- Override MOD=17, CONST=5: exhaustive x=0..31, random out_ready -> results match (x*5) mod 17; out_err set exactly for x >= 17.

Source files
------------

// File: rtl/mod_const_mac_pipe_pkg.sv
// Shared helpers and types for the constant residue multiply/accumulate pipe.
package mod_calc_pkg;

  // Widest residue this unit supports (MOD <= 65535).
  localparam int DATA_MAX_W = 16;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // floor(2^(2W) / MOD); 64-bit math so that W = 16 does not overflow.
  function automatic longint barrett_mu(input int m, input int w);
    return (longint'(1) << (2 * w)) / longint'(m);
  endfunction

  function automatic int const_reduce(input int c, input int m);
    return c % m;
  endfunction

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MAC    = 2'b01,
    MODE_CLRMAC = 2'b10
  } mode_e;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    mode_e                 mode;
    logic [DATA_MAX_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/mod_const_mac_pipe_if.sv
// Input/output stream bundle of the residue multiply/accumulate pipe.
interface mod_const_mac_pipe_if #(
  parameter int W = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;
  logic [W-1:0] acc_value;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, acc_value
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, acc_value
  );
endinterface

// File: rtl/mod_const_mac_pipe_barrett.sv
// Barrett reduction of a 2W-bit product: estimate registered in S2,
// final correction subtractions are combinational into S3.
module mod_reduce_barrett
  import mod_calc_pkg::*;
#(
  parameter int MOD = 53,
  parameter int W   = 6
) (
  input  logic           clk,
  input  logic           en_i,
  input  logic [2*W-1:0] p_i,
  output logic [W-1:0]   res_o
);

  localparam logic [W:0]   MU    = (W + 1)'(barrett_mu(MOD, W));
  localparam logic [W:0]   MOD_L = (W + 1)'(MOD);
  localparam logic [W+1:0] MOD_R = (W + 2)'(MOD);

  logic [W:0]     q;
  logic [2*W+1:0] qm;
  logic [W+1:0]   r_d, r_q;
  logic [W+1:0]   t1, t2;

  // Quotient estimate and remainder; the remainder is below 3*MOD so W+2 bits hold it.
  always_comb begin
    q   = (W + 1)'(({{(W + 1){1'b0}}, p_i} * {{(2 * W){1'b0}}, MU}) >> (2 * W));
    qm  = {{(W + 1){1'b0}}, q} * {{(W + 1){1'b0}}, MOD_L};
    r_d = (W + 2)'({2'b00, p_i} - qm);
  end

  // S2 register: holds the unreduced remainder.
  always_ff @(posedge clk) begin
    if (en_i) r_q <= r_d;
  end

  // Two conditional subtractions bring the remainder into 0..MOD-1.
  always_comb begin
    t1    = (r_q >= MOD_R) ? r_q - MOD_R : r_q;
    t2    = (t1 >= MOD_R) ? t1 - MOD_R : t1;
    res_o = W'(t2);
  end

endmodule

// File: rtl/mod_const_mac_pipe.sv
// Streaming (x * CONST) mod MOD with optional modular accumulate.
// S1 registers the beat, S2 holds the Barrett remainder, S3 is the output.
module mod_const_mac_pipe
  import mod_calc_pkg::*;
#(
  parameter int MOD   = 53,
  parameter int CONST = 400
) (
  input logic                 clk,
  input logic                 rst,
  mod_const_mac_pipe_if.slave bus
);

  localparam int         W     = clog2_f(MOD);
  localparam logic [W-1:0] K_L = W'(const_reduce(CONST, MOD));
  localparam logic [W:0] MOD_L = (W + 1)'(MOD);

  stage_t         s1_q, s1_d;
  logic           v2_q, err2_q;
  mode_e          mode2_q;
  logic           v3_q, err3_q;
  logic [W-1:0]   out_q, acc_q;
  logic [W-1:0]   res_s2, res_d, acc_d, acc_mac;
  logic [W:0]     acc_sum;
  logic [2*W-1:0] p_s1;
  logic           ld1, ld2, ld3;

  // A stage loads when it is empty or its contents move on downstream.
  assign ld3 = ~v3_q | bus.out_ready;
  assign ld2 = ~v2_q | ld3;
  assign ld1 = ~s1_q.valid | ld2;

  assign bus.in_ready  = ld1 & ~rst;
  assign bus.out_valid = v3_q;
  assign bus.out_data  = out_q;
  assign bus.out_err   = err3_q;
  assign bus.acc_value = acc_q;

  // Capture the incoming beat; the reserved mode folds to plain multiply.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = bus.in_valid;
    s1_d.err   = ({1'b0, bus.in_data} >= MOD_L);
    s1_d.mode  = (bus.in_mode == 2'b11) ? MODE_MUL : mode_e'(bus.in_mode);
    s1_d.data  = DATA_MAX_W'(bus.in_data);
  end

  // S1 register.
  always_ff @(posedge clk) begin
    if (rst)      s1_q <= '0;
    else if (ld1) s1_q <= s1_d;
  end

  // Error beats feed a zero product so the reducer never sees out-of-range data.
  assign p_s1 = s1_q.err ? '0 : (2 * W)'(32'(s1_q.data) * 32'(K_L));

  mod_reduce_barrett #(.MOD(MOD), .W(W)) u_reduce (
    .clk  (clk),
    .en_i (ld2),
    .p_i  (p_s1),
    .res_o(res_s2)
  );

  // S2 control fields travel alongside the remainder held in the reducer.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      err2_q  <= 1'b0;
      mode2_q <= MODE_MUL;
    end else if (ld2) begin
      v2_q    <= s1_q.valid;
      err2_q  <= s1_q.err;
      mode2_q <= s1_q.mode;
    end
  end

  // Result and accumulator next value; acc + res never exceeds 2*MOD-2.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, res_s2};
    acc_mac = (acc_sum >= MOD_L) ? W'(acc_sum - MOD_L) : W'(acc_sum);
    res_d   = res_s2;
    acc_d   = acc_q;
    if (err2_q) begin
      res_d = '0;
    end else begin
      case (mode2_q)
        MODE_MAC: begin
          acc_d = acc_mac;
          res_d = acc_mac;
        end
        MODE_CLRMAC: acc_d = res_s2;
        default:     acc_d = acc_q;
      endcase
    end
  end

  // S3 output register; the accumulator commits only when its beat loads S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      out_q  <= '0;
      err3_q <= 1'b0;
      acc_q  <= '0;
    end else if (ld3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_q  <= res_d;
        err3_q <= err2_q;
        acc_q  <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_mod_const_mac_pipe.sv
// Directed bench for mod_const_mac_pipe: default MOD=53/CONST=400 instance
// plus a MOD=17/CONST=5 instance swept exhaustively under random backpressure.
module tb_mod_const_mac_pipe;

  logic clk;
  logic rst_a, rst_b;
  int   cyc;
  int   n_cmp, n_mis;
  int   unstable;
  bit   done_b;

  int qa_data[$], qa_err[$], qa_cyc[$], ina_cyc[$];
  int qb_data[$], qb_err[$];

  mod_const_mac_pipe_if #(.W(6)) ifa ();
  mod_const_mac_pipe_if #(.W(5)) ifb ();

  mod_const_mac_pipe #(.MOD(53), .CONST(400)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  mod_const_mac_pipe #(.MOD(17), .CONST(5))   dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer logs, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready) begin
      qa_data.push_back(int'(ifa.out_data));
      qa_err.push_back(int'(ifa.out_err));
      qa_cyc.push_back(cyc);
    end
    if (ifa.in_valid && ifa.in_ready) ina_cyc.push_back(cyc);
    if (ifb.out_valid && ifb.out_ready) begin
      qb_data.push_back(int'(ifb.out_data));
      qb_err.push_back(int'(ifb.out_err));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_a();
    qa_data.delete(); qa_err.delete(); qa_cyc.delete(); ina_cyc.delete();
  endtask

  task automatic send_a(input int x, input int m);
    int t;
    t = 0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = 6'(x);
    ifa.in_mode  = 2'(m);
    @(negedge clk);
    while (!ifa.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_a_timeout", t, 0);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input int x, input int m);
    int t;
    t = 0;
    ifb.in_valid = 1'b1;
    ifb.in_data  = 5'(x);
    ifb.in_mode  = 2'(m);
    @(negedge clk);
    while (!ifb.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_b_timeout", t, 0);
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
  endtask

  task automatic wait_out_a(input int n);
    int t;
    t = 0;
    while (qa_data.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    check("wait_a_count", qa_data.size(), n);
  endtask

  task automatic wait_out_b(input int n);
    int t;
    t = 0;
    while (qb_data.size() < n && t < 400) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    check("wait_b_count", qb_data.size(), n);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: time %0t exceeded limit 300000", $time);
    $fatal(1);
  end

  initial begin
    int e1[3];
    int e2[3];
    int e4[5];
    n_cmp = 0; n_mis = 0; unstable = 0; done_b = 1'b1;
    e1 = '{29, 5, 24};
    e2 = '{29, 5, 5};
    e4 = '{34, 10, 39, 15, 44};
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_mode = 2'b00; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_mode = 2'b00; ifb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  ifa.in_ready, 0);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_out_data",  ifa.out_data, 0);
    check("rst_out_err",   ifa.out_err, 0);
    check("rst_acc",       ifa.acc_value, 0);
    check("rst_b_valid",   ifb.out_valid, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Plain multiply, back to back, with latency check.
    clear_a();
    send_a(1, 0); send_a(2, 0); send_a(52, 0);
    wait_out_a(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mul_data[%0d]", i), qa_data[i], e1[i]);
      check($sformatf("mul_err[%0d]", i), qa_err[i], 0);
      check($sformatf("mul_lat[%0d]", i), qa_cyc[i] - ina_cyc[i], 3);
    end
    check("mul_spacing", qa_cyc[2] - qa_cyc[0], 2);
    check("mul_acc", ifa.acc_value, 0);

    // Accumulate, then clear-and-load.
    clear_a();
    send_a(1, 1); send_a(1, 1); send_a(2, 2);
    wait_out_a(3);
    for (int i = 0; i < 3; i++)
      check($sformatf("mac_data[%0d]", i), qa_data[i], e2[i]);
    check("mac_acc", ifa.acc_value, 5);

    // Error beat must not disturb the accumulator.
    clear_a();
    send_a(1, 2); send_a(53, 1);
    wait_out_a(2);
    check("err_pre_data", qa_data[0], 29);
    check("err_data", qa_data[1], 0);
    check("err_flag", qa_err[1], 1);
    check("err_acc", ifa.acc_value, 29);

    // Backpressure during a 5-beat burst.
    clear_a();
    ifa.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_a(3 + i, 0);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (ifa.out_valid && ifa.out_data != 6'd34) unstable++;
        end
        check("stall_in_ready", ifa.in_ready, 0);
        check("stall_accepted", ina_cyc.size(), 3);
        check("stall_out_valid", ifa.out_valid, 1);
        check("stall_no_out", qa_data.size(), 0);
        check("stall_stable", unstable, 0);
        check("stall_hold_data", ifa.out_data, 34);
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
      end
    join
    wait_out_a(5);
    for (int i = 0; i < 5; i++)
      check($sformatf("burst_data[%0d]", i), qa_data[i], e4[i]);
    check("burst_acc", ifa.acc_value, 29);

    // Reset with two beats in flight.
    clear_a();
    send_a(10, 1); send_a(11, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("flush_no_out", qa_data.size(), 0);
    check("flush_valid", ifa.out_valid, 0);
    check("flush_acc", ifa.acc_value, 0);
    @(posedge clk); #1;
    clear_a();
    send_a(3, 0); send_a(2, 3);
    wait_out_a(2);
    check("post_rst_data", qa_data[0], 34);
    check("mode11_data", qa_data[1], 5);
    check("mode11_acc", ifa.acc_value, 0);

    // Exhaustive sweep of the 17/5 instance under random out_ready.
    qb_data.delete(); qb_err.delete();
    done_b = 1'b0;
    fork
      begin
        while (!done_b) begin
          @(posedge clk); #1;
          ifb.out_ready = 1'($urandom_range(0, 1));
        end
        ifb.out_ready = 1'b1;
      end
    join_none
    for (int x = 0; x < 32; x++) send_b(x, 0);
    wait_out_b(32);
    done_b = 1'b1;
    for (int x = 0; x < 32; x++) begin
      check($sformatf("m17_data[%0d]", x), qb_data[x], (x < 17) ? (x * 5) % 17 : 0);
      check($sformatf("m17_err[%0d]", x), qb_err[x], (x >= 17) ? 1 : 0);
    end
    check("m17_acc", ifb.acc_value, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
